// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - register file dump sequencer; DUMP_CHECKSUM_EN adds a trailing checksum beat
module reg_dump_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ADDR_WIDTH-1:0] READADDR,
  input  logic [DATA_WIDTH-1:0] REGDATA,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [ADDR_WIDTH-1:0] OUT_ADDR,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  OUT_CSUM,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] VLD  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] count;

  assign READADDR = count;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  // sum covers register beats only; OUT_CSUM marks the extra beat that follows the last one
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sum      <= '0;
      OUT_CSUM <= 1'b0;
    end else if (state != IDLE && ABORT) begin
      OUT_CSUM <= 1'b0;
    end else if (state == IDLE && START) begin
      sum      <= '0;
      OUT_CSUM <= 1'b0;
    end else if (state == VLD && OUT_READY) begin
      if (OUT_LAST) begin
        OUT_CSUM <= 1'b0;
      end else begin
        sum      <= sum + OUT_DATA;
        OUT_CSUM <= (count == LAST_ADDR);
      end
    end
  end
`else
  assign OUT_CSUM = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      count     <= '0;
      OUT_DATA  <= '0;
      OUT_ADDR  <= '0;
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state != IDLE && ABORT) begin
        state     <= IDLE;
        OUT_VALID <= 1'b0;
        OUT_LAST  <= 1'b0;
        BUSY      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              state <= RD;
              count <= '0;
              BUSY  <= 1'b1;
            end
          end
          RD: begin
            OUT_DATA  <= REGDATA;
            OUT_ADDR  <= count;
`ifdef DUMP_CHECKSUM_EN
            OUT_LAST  <= 1'b0;
`else
            OUT_LAST  <= (count == LAST_ADDR);
`endif
            OUT_VALID <= 1'b1;
            state     <= VLD;
          end
          VLD: begin
            if (OUT_READY) begin
              if (OUT_LAST) begin
                state     <= FIN;
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
                DONE      <= 1'b1;
              end
`ifdef DUMP_CHECKSUM_EN
              else if (count == LAST_ADDR) begin
                // checksum beat goes out back-to-back, VALID stays high
                OUT_DATA <= sum + OUT_DATA;
                OUT_ADDR <= '0;
                OUT_LAST <= 1'b1;
              end
`endif
              else begin
                count     <= count + 1'b1;
                OUT_VALID <= 1'b0;
                state     <= RD;
              end
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - directed table-driven bench for reg_dump_reader
module tb_reg_dump_reader;

`ifdef DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  localparam int NBEATS = CS ? 9 : 8;

  logic       CLK, RESET, START, ABORT, OUT_READY;
  logic [2:0] READADDR, OUT_ADDR;
  logic [7:0] REGDATA, OUT_DATA;
  logic       OUT_VALID, OUT_LAST, OUT_CSUM, BUSY, DONE;

  logic [7:0] regs [8];
  assign REGDATA = regs[READADDR];

  reg_dump_reader dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .READADDR(READADDR), .REGDATA(REGDATA),
    .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .OUT_CSUM(OUT_CSUM),
    .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    logic [7:0] regval;
    logic [2:0] addr;
    logic [7:0] data;
    logic       last;
    logic       csum;
  } vec_t;

  vec_t vec [9];
  int   tests = 0;
  int   fails = 0;

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int kind);
    logic [7:0] v;
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v = (kind == 0) ? 8'(i + 1) : 8'hFF;
      vec[i] = '{v, 3'(i), v, (i == 7) && !CS, 1'b0};
      regs[i] = vec[i].regval;
      s = s + v;
    end
    vec[8] = '{8'h00, 3'd0, s, 1'b1, 1'b1};
  endtask

  task automatic run_dump(input string tag, input int stall_at, input int abort_at,
                          input int reset_at, input int pulse_at,
                          input bit hold_end, input bit start_abort);
    int w;
    bit bad;
    ABORT = start_abort;
    START = 1'b1;
    step();
    START = 1'b0;
    ABORT = 1'b0;
    chk({tag, " busy@start"}, BUSY, 1);
    chk({tag, " valid@start"}, OUT_VALID, 0);
    for (int i = 0; i < NBEATS; i++) begin
      w = 0;
      while (!OUT_VALID && w < 20) begin
        step();
        w++;
        if (i > 0 && i - 1 == pulse_at) START = 1'b0;
      end
      if (!OUT_VALID) begin
        chk($sformatf("%s timeout beat %0d", tag, i), 0, 1);
        return;
      end
      chk($sformatf("%s gap %0d", tag, i), w, vec[i].csum ? 0 : 1);
      chk($sformatf("%s addr %0d", tag, i), OUT_ADDR, vec[i].addr);
      chk($sformatf("%s data %0d", tag, i), OUT_DATA, vec[i].data);
      chk($sformatf("%s last %0d", tag, i), OUT_LAST, vec[i].last);
      chk($sformatf("%s csum %0d", tag, i), OUT_CSUM, vec[i].csum);
      if (i == reset_at) begin
        RESET = 1'b0;
        #1;
        chk({tag, " rst valid"}, OUT_VALID, 0);
        chk({tag, " rst busy"}, BUSY, 0);
        chk({tag, " rst outs"}, {READADDR, OUT_ADDR, OUT_DATA, OUT_LAST, OUT_CSUM, DONE}, 0);
        step();
        RESET = 1'b1;
        step();
        chk({tag, " rst idle"}, BUSY, 0);
        return;
      end
      if (i == stall_at) begin
        OUT_READY = 1'b0;
        bad = 1'b0;
        repeat (5) begin
          step();
          if (!OUT_VALID || OUT_DATA !== vec[i].data || OUT_ADDR !== vec[i].addr) bad = 1'b1;
        end
        chk({tag, " stall hold"}, bad, 0);
        OUT_READY = 1'b1;
      end
      if (i == pulse_at) START = 1'b1;
      if (i == NBEATS - 1 && hold_end) START = 1'b1;
      if (i == abort_at) begin
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk({tag, " abort valid"}, OUT_VALID, 0);
        chk({tag, " abort busy"}, BUSY, 0);
        bad = DONE;
        repeat (12) begin
          step();
          if (OUT_VALID || DONE) bad = 1'b1;
        end
        chk({tag, " abort quiet"}, bad, 0);
        return;
      end
      step();
    end
    chk({tag, " done pulse"}, DONE, 1);
    chk({tag, " valid after last"}, OUT_VALID, 0);
    chk({tag, " busy in fin"}, BUSY, 1);
    step();
    chk({tag, " done low"}, DONE, 0);
    chk({tag, " busy idle"}, BUSY, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    CLK = 1'b0; RESET = 1'b0; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    repeat (2) step();
    chk("reset valid", OUT_VALID, 0);
    chk("reset busy", BUSY, 0);
    chk("reset outs", {READADDR, OUT_ADDR, OUT_DATA, OUT_LAST, OUT_CSUM, DONE}, 0);
    RESET = 1'b1;
    step();

    load(0);
    run_dump("basic", -1, -1, -1, -1, 1'b0, 1'b0);
    run_dump("stall", 3, -1, -1, -1, 1'b0, 1'b0);
    run_dump("abort", -1, 4, -1, -1, 1'b0, 1'b0);
    run_dump("midrst", -1, -1, 2, -1, 1'b0, 1'b0);
    run_dump("afterrst", -1, -1, -1, -1, 1'b0, 1'b0);
    run_dump("busystart", -1, -1, -1, 1, 1'b1, 1'b0);
    run_dump("heldstart", -1, -1, -1, -1, 1'b0, 1'b0);
    run_dump("startabort", -1, -1, -1, -1, 1'b0, 1'b1);

    ABORT = 1'b1;
    step();
    chk("idle abort busy", BUSY, 0);
    chk("idle abort valid", OUT_VALID, 0);
    ABORT = 1'b0;
    step();

    load(1);
    run_dump("allff", -1, -1, -1, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
